// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit: next-PC mode encoding,
// default geometry constants and the alignment-mask helper.
package pc_pkg;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2,
      PC_RETURN = 2'd3
   } pc_mode_e;

   localparam int PC_WIDTH_DEF     = 32;
   localparam int PC_STEP_DEF      = 4;
   localparam int PC_RAS_DEPTH_DEF = 4;

   // Mask of the address bits below the instruction step (STEP is a power of two).
   function automatic logic [63:0] pc_align_mask(input int unsigned step);
      logic [63:0] s;
      s = 64'(step);
      return s - 64'd1;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. Pushing onto a full stack overwrites the oldest
// entry; count saturates at RAS_DEPTH. Overflow/underflow are registered pulses.
module pc_ras
   import pc_pkg::*;
#(
   parameter int WIDTH     = PC_WIDTH_DEF,
   parameter int RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             push_data,
   output logic [WIDTH-1:0]             top,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(RAS_DEPTH):0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int PTR_W = $clog2(RAS_DEPTH);

   logic [WIDTH-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_prev;
   logic [PTR_W:0]   cnt;

   // ptr is the next free slot; the top entry sits just below it, modulo depth.
   assign ptr_prev  = ptr - PTR_W'(1);
   assign top       = mem[ptr_prev];
   assign full      = (cnt == (PTR_W+1)'(RAS_DEPTH));
   assign empty     = (cnt == '0);
   assign count     = cnt;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= push && full;
         underflow <= pop && !push && empty;
         if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (!full) begin
               cnt <= cnt + (PTR_W+1)'(1);
            end
         end else if (pop && !empty) begin
            ptr <= ptr_prev;
            cnt <= cnt - (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with sequential/branch/jump/return selection.
// Define PC_RAS_EN to build the return-address stack; otherwise RETURN steps like SEQ.
module pc_unit
   import pc_pkg::*;
#(
   parameter int               WIDTH     = PC_WIDTH_DEF,
   parameter int               STEP      = PC_STEP_DEF,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter int               RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [1:0]        mode,
   input  logic              branch_taken,
   input  logic [WIDTH-1:0]  imm,
   input  logic [WIDTH-1:0]  target,
   input  logic              call,
   output logic [WIDTH-1:0]  pc_out,
   output logic              misaligned,
   output logic              ras_overflow,
   output logic              ras_underflow
);

   localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(pc_align_mask(STEP));
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

   pc_mode_e                 mode_e;
   logic        [WIDTH-1:0]  pc_p1;
   logic                     misaligned_p1;
   logic signed [WIDTH-1:0]  imm_s;
   logic        [WIDTH-1:0]  seq_p0;
   logic        [WIDTH-1:0]  next_p0;
   logic        [WIDTH-1:0]  ret_addr;
   logic                     ret_valid;

   assign mode_e = pc_mode_e'(mode);
   assign imm_s  = signed'(imm);
   assign seq_p0 = pc_p1 + STEP_W;

`ifdef PC_RAS_EN
   logic                        ras_push;
   logic                        ras_pop;
   logic                        ras_full;
   logic                        ras_empty;
   logic [$clog2(RAS_DEPTH):0]  ras_count;
   logic                        unused_ras;

   assign ras_push   = !stall && (mode_e == PC_JUMP) && call;
   assign ras_pop    = !stall && (mode_e == PC_RETURN);
   assign ret_valid  = !ras_empty;
   assign unused_ras = &{1'b0, ras_full, ras_count};

   pc_ras #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (seq_p0),
      .top       (ret_addr),
      .full      (ras_full),
      .empty     (ras_empty),
      .count     (ras_count),
      .overflow  (ras_overflow),
      .underflow (ras_underflow)
   );
`else
   logic unused_call;

   assign ret_valid     = 1'b0;
   assign ret_addr      = '0;
   assign ras_overflow  = 1'b0;
   assign ras_underflow = 1'b0;
   assign unused_call   = &{1'b0, call};
`endif

   always_comb begin
      next_p0 = seq_p0;
      unique case (mode_e)
         PC_SEQ:    next_p0 = seq_p0;
         PC_BRANCH: next_p0 = branch_taken ? WIDTH'($signed(pc_p1) + imm_s) : seq_p0;
         PC_JUMP:   next_p0 = target;
         PC_RETURN: next_p0 = ret_valid ? ret_addr : seq_p0;
         default:   next_p0 = seq_p0;
      endcase
   end

   // p0 -> p1: align and register the selected address
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_p1         <= RESET_VEC;
         misaligned_p1 <= 1'b0;
      end else if (stall) begin
         misaligned_p1 <= 1'b0;
      end else begin
         pc_p1         <= next_p0 & ~LOW_MASK;
         misaligned_p1 <= |(next_p0 & LOW_MASK);
      end
   end

   assign pc_out     = pc_p1;
   assign misaligned = misaligned_p1;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; expectations follow the build (PC_RAS_EN defined or not).
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [1:0]  mode;
   logic        branch_taken;
   logic [31:0] imm;
   logic [31:0] target;
   logic        call;
   logic [31:0] pc_out;
   logic        misaligned;
   logic        ras_overflow;
   logic        ras_underflow;

   int tests = 0;
   int fails = 0;

`ifdef PC_RAS_EN
   localparam bit RAS = 1'b1;
`else
   localparam bit RAS = 1'b0;
`endif

   pc_unit #(
      .WIDTH     (32),
      .STEP      (4),
      .RESET_VEC (32'h0),
      .RAS_DEPTH (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .mode          (mode),
      .branch_taken  (branch_taken),
      .imm           (imm),
      .target        (target),
      .call          (call),
      .pc_out        (pc_out),
      .misaligned    (misaligned),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [1:0] m, input logic tk, input logic [31:0] im,
                        input logic [31:0] tg, input logic cl);
      mode = m; branch_taken = tk; imm = im; target = tg; call = cl;
      cycle();
   endtask

   task automatic flags(input string tag, input logic mis, input logic ovf, input logic unf);
      check({tag, ".mis"}, 32'(misaligned), 32'(mis));
      check({tag, ".ovf"}, 32'(ras_overflow), 32'(ovf));
      check({tag, ".unf"}, 32'(ras_underflow), 32'(unf));
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; mode = 2'd0; branch_taken = 1'b0;
      imm = '0; target = '0; call = 1'b0;
      cycle();
      cycle();
      check("reset.pc", pc_out, 32'h0);
      flags("reset", 1'b0, 1'b0, 1'b0);

      reset = 1'b0;
      apply(2'd0, 0, 0, 0, 0); check("seq1", pc_out, 32'd4);
      apply(2'd0, 0, 0, 0, 0); check("seq2", pc_out, 32'd8);
      apply(2'd0, 0, 0, 0, 0); check("seq3", pc_out, 32'd12);
      reset = 1'b1;
      apply(2'd0, 0, 0, 0, 0); check("midreset.pc", pc_out, 32'd0);
      reset = 1'b0;

      apply(2'd2, 0, 0, 32'd100, 0); check("jmp100", pc_out, 32'd100);
      apply(2'd1, 1, -32'sd8, 0, 0); check("br.taken", pc_out, 32'd92);
      apply(2'd2, 0, 0, 32'd100, 0);
      apply(2'd1, 0, -32'sd8, 0, 0); check("br.nottaken", pc_out, 32'd104);

      apply(2'd2, 0, 0, 32'hFFFF_FFFC, 0); check("jmp.top", pc_out, 32'hFFFF_FFFC);
      apply(2'd0, 0, 0, 0, 0); check("wrap.pc", pc_out, 32'h0);
      flags("wrap", 1'b0, 1'b0, 1'b0);

      apply(2'd2, 0, 0, 32'd40, 0);
      apply(2'd2, 0, 0, 32'h200, 1); check("call.pc", pc_out, 32'h200);
      apply(2'd3, 0, 0, 0, 0); check("ret1.pc", pc_out, RAS ? 32'd44 : 32'h204);
      flags("ret1", 1'b0, 1'b0, 1'b0);
      apply(2'd3, 0, 0, 0, 0); check("ret2.pc", pc_out, RAS ? 32'd48 : 32'h208);
      flags("ret2", 1'b0, 1'b0, RAS);
      apply(2'd0, 0, 0, 0, 0); flags("after.unf", 1'b0, 1'b0, 1'b0);

      // five calls into a 4-deep stack: the 5th drops the oldest
      apply(2'd2, 0, 0, 32'h1000, 1);
      apply(2'd2, 0, 0, 32'h2000, 1);
      apply(2'd2, 0, 0, 32'h3000, 1);
      apply(2'd2, 0, 0, 32'h4000, 1); flags("push4", 1'b0, 1'b0, 1'b0);
      apply(2'd2, 0, 0, 32'h5000, 1); check("push5.pc", pc_out, 32'h5000);
      flags("push5", 1'b0, RAS, 1'b0);
      apply(2'd3, 0, 0, 0, 0); check("pop1", pc_out, RAS ? 32'h4004 : 32'h5004);
      flags("pop1", 1'b0, 1'b0, 1'b0);
      apply(2'd3, 0, 0, 0, 0); check("pop2", pc_out, RAS ? 32'h3004 : 32'h5008);
      apply(2'd3, 0, 0, 0, 0); check("pop3", pc_out, RAS ? 32'h2004 : 32'h500C);
      apply(2'd3, 0, 0, 0, 0); check("pop4", pc_out, RAS ? 32'h1004 : 32'h5010);
      apply(2'd3, 0, 0, 0, 0); check("pop5", pc_out, RAS ? 32'h1008 : 32'h5014);
      flags("pop5", 1'b0, 1'b0, RAS);

      apply(2'd2, 0, 0, 32'h103, 0); check("mis.pc", pc_out, 32'h100);
      flags("mis", 1'b1, 1'b0, 1'b0);
      stall = 1'b1;
      apply(2'd2, 0, 0, 32'h800, 1); check("stall.pc", pc_out, 32'h100);
      flags("stall", 1'b0, 1'b0, 1'b0);
      stall = 1'b0;
      apply(2'd3, 0, 0, 0, 0); check("stall.ret", pc_out, 32'h104);
      flags("stall.ret", 1'b0, 1'b0, RAS);

      apply(2'd2, 0, 0, 32'h300, 1);
      reset = 1'b1;
      apply(2'd3, 0, 0, 0, 0); check("rst.ras.pc", pc_out, 32'h0);
      reset = 1'b0;
      apply(2'd3, 0, 0, 0, 0); check("rst.ras.ret", pc_out, 32'h4);
      flags("rst.ras", 1'b0, 1'b0, RAS);

      apply(2'd1, 1, 32'd6, 0, 0); check("br.mis.pc", pc_out, 32'h8);
      flags("br.mis", 1'b1, 1'b0, 1'b0);
      apply(2'd0, 0, 0, 0, 1); check("seq.call", pc_out, 32'hC);
      apply(2'd3, 0, 0, 0, 0); check("seq.call.ret", pc_out, 32'h10);
      flags("seq.call", 1'b0, 1'b0, RAS);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
